// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin arbiter that lets NREQ local requesters share
// one APB master port. It latches the winning request, runs SETUP/ACCESS
// with a psel1/psel2 decode on paddr[AW-1], and returns a one-cycle done
// pulse with read data and error status.
module apb_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic               psel1,
  output logic               psel2,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int          IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   winner;
  logic [7:0]      wait_cnt;

  logic [NREQ-1:0] elig;
  logic            grant_vld;
  logic [IW-1:0]   grant_idx;
  logic            grant_write;
  logic [AW-1:0]   grant_addr;
  logic [DW-1:0]   grant_wdata;
  int              idx;

  // Wrap-around increment used to move the round-robin pointer past the winner.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] cur);
    if (cur == IW'(NREQ - 1)) return '0;
    return cur + IW'(1);
  endfunction

  // Pick the first eligible requester searching upward from ptr; a requester
  // whose done pulse is showing this cycle is masked so it cannot win again.
  always_comb begin
    elig        = req & ~done;
    grant_vld   = 1'b0;
    grant_idx   = '0;
    grant_write = 1'b0;
    grant_addr  = '0;
    grant_wdata = '0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!grant_vld && elig[idx]) begin
        grant_vld   = 1'b1;
        grant_idx   = IW'(idx);
        grant_write = req_write[idx];
        grant_addr  = req_addr[idx*AW +: AW];
        grant_wdata = req_wdata[idx*DW +: DW];
      end
    end
  end

  // Transfer sequencer: IDLE arbitration, one SETUP cycle, ACCESS until
  // pready or timeout. done/rsp_* default low so they pulse for one cycle.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      ptr       <= '0;
      winner    <= '0;
      wait_cnt  <= '0;
      psel1     <= 1'b0;
      psel2     <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      done      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      done      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            winner   <= grant_idx;
            pwrite   <= grant_write;
            paddr    <= grant_addr;
            pwdata   <= grant_write ? grant_wdata : '0;
            psel1    <= ~grant_addr[AW-1];
            psel2    <= grant_addr[AW-1];
            wait_cnt <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready || wait_cnt == TO_LAST) begin
            // pready takes priority over a timeout landing on the same edge
            done[winner] <= 1'b1;
            rsp_err      <= pready ? pslverr : 1'b1;
            rsp_rdata    <= (pready && !pwrite && !pslverr) ? prdata : '0;
            ptr          <= next_idx(winner);
            psel1        <= 1'b0;
            psel2        <= 1'b0;
            penable      <= 1'b0;
            wait_cnt     <= '0;
            state        <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
